// File: rtl/reset_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared types and defaults for the staged reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    // Sequencer states; all four encodings are used, and the decoder still
    // falls back to ST_ASSERT for anything unexpected.
    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_STAGE  = 2'd2,
        ST_RUN    = 2'd3
    } seq_state_e;

    localparam int DEFAULT_HOLD_CYCLES = 16;
    localparam int DEFAULT_STAGE_GAP   = 4;

    // Larger of two integers; used to size the shared hold/gap timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_event_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : reset_event_counter
// Description : Rising-edge detector on the reset request plus a saturating
//               event counter for debug readout.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_event_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             req_prev_q;
    logic             req_prev_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count only new rising edges of req, and stick at all-ones.
    always_comb begin
        req_prev_d = req;
        count_d    = count_q;
        if (req && !req_prev_q && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Edge-history and count registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_prev_q <= 1'b0;
            count_q    <= '0;
        end else begin
            req_prev_q <= req_prev_d;
            count_q    <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Turns a clk-aligned reset request into a staged release:
//               core leaves reset first, UART after a fixed gap, then ready.
//               Also exposes a saturating count of reset requests.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEFAULT_STAGE_GAP,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reset_req,
    output logic             core_reset,
    output logic             uart_reset,
    output logic             ready,
    output logic             busy,
    output logic [CNT_W-1:0] reset_count
);

    localparam int TMR_MAX = max_int(HOLD_CYCLES, STAGE_GAP);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] STAGE_LAST = TMR_W'(STAGE_GAP - 1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             core_reset_q;
    logic             core_reset_d;
    logic             uart_reset_q;
    logic             uart_reset_d;
    logic             ready_q;
    logic             ready_d;
    logic             busy_q;
    logic             busy_d;

    // Next state and timer; a request always wins over a terminal count.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_ASSERT: begin
                timer_d = '0;
                if (!reset_req) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (reset_req) begin
                    state_d = ST_ASSERT;
                    timer_d = '0;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = ST_STAGE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_STAGE: begin
                if (reset_req) begin
                    state_d = ST_ASSERT;
                    timer_d = '0;
                end else if (timer_q == STAGE_LAST) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RUN: begin
                timer_d = '0;
                if (reset_req) begin
                    state_d = ST_ASSERT;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                timer_d = '0;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // change exactly with the state register and never glitch.
        core_reset_d = (state_d == ST_ASSERT) || (state_d == ST_HOLD);
        uart_reset_d = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
        busy_d       = (state_d != ST_RUN);
    end

    // State, timer and output registers; async reset forces full reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ASSERT;
            timer_q      <= '0;
            core_reset_q <= 1'b1;
            uart_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            core_reset_q <= core_reset_d;
            uart_reset_q <= uart_reset_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign core_reset = core_reset_q;
    assign uart_reset = uart_reset_q;
    assign ready      = ready_q;
    assign busy       = busy_q;

    reset_event_counter #(
        .CNT_W (CNT_W)
    ) u_event_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (reset_req),
        .count (reset_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Scoreboard bench for reset_sequencer. Stimulus queues the
//               expected output changes (edge number + values); monitors pop
//               and compare whenever the DUT outputs change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    typedef struct {
        int         cyc;
        logic       core;
        logic       uart;
        logic       rdy;
        logic       bsy;
        logic [7:0] cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       reset_req;
    logic       reset_req2;
    logic       core_reset, uart_reset, ready, busy;
    logic [7:0] reset_count;
    logic       core2, uart2, ready2, busy2;
    logic [1:0] count2;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    ev_t  exp_q[$];
    logic [1:0] exp2_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reset_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reset_req   (reset_req),
        .core_reset  (core_reset),
        .uart_reset  (uart_reset),
        .ready       (ready),
        .busy        (busy),
        .reset_count (reset_count)
    );

    reset_sequencer #(.CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .reset_req   (reset_req2),
        .core_reset  (core2),
        .uart_reset  (uart2),
        .ready       (ready2),
        .busy        (busy2),
        .reset_count (count2)
    );

    task automatic expect_ev(input int c, input logic co, input logic u,
                             input logic r, input logic b, input logic [7:0] n);
        ev_t e;
        e.cyc = c; e.core = co; e.uart = u; e.rdy = r; e.bsy = b; e.cnt = n;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor for the main DUT: every change of the output vector is one check.
    initial begin
        ev_t         e;
        logic [11:0] prev;
        logic [11:0] cur;
        prev = {core_reset, uart_reset, ready, busy, reset_count};
        forever begin
            @(core_reset or uart_reset or ready or busy or reset_count);
            #1;
            cur = {core_reset, uart_reset, ready, busy, reset_count};
            if (cur !== prev) begin
                prev = cur;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change edge=%0d got core=%b uart=%b ready=%b busy=%b count=%0d, required no change",
                             cyc, core_reset, uart_reset, ready, busy, reset_count);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || core_reset !== e.core || uart_reset !== e.uart ||
                        ready !== e.rdy || busy !== e.bsy || reset_count !== e.cnt) begin
                        $display("FAIL output_event got edge=%0d core=%b uart=%b ready=%b busy=%b count=%0d, required edge=%0d core=%b uart=%b ready=%b busy=%b count=%0d",
                                 cyc, core_reset, uart_reset, ready, busy, reset_count,
                                 e.cyc, e.core, e.uart, e.rdy, e.bsy, e.cnt);
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
    end

    // Monitor for the narrow-counter DUT: read the count when each pulse ends.
    initial begin
        logic [1:0] e2;
        @(posedge rst_n);
        forever begin
            @(negedge reset_req2);
            #1;
            n_checks++;
            if (exp2_q.size() == 0) begin
                $display("FAIL sat_count got %0d, required no pending readout", count2);
            end else begin
                e2 = exp2_q.pop_front();
                if (count2 !== e2) begin
                    $display("FAIL sat_count got %0d, required %0d", count2, e2);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired at edge %0d, required bench completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst_n      = 1'b1;
        reset_req  = 1'b0;
        reset_req2 = 1'b0;

        // Power-up: reset values appear asynchronously, before any edge.
        #2;
        expect_ev(0, 1, 1, 0, 1, 0);
        rst_n = 1'b0;
        step(3);
        b = cyc;
        expect_ev(b + 17, 0, 1, 0, 1, 0);
        expect_ev(b + 21, 0, 0, 1, 0, 0);
        rst_n = 1'b1;
        step(24);

        // Request in RUN held for 5 cycles.
        b = cyc;
        expect_ev(b + 1,  1, 1, 0, 1, 1);
        expect_ev(b + 22, 0, 1, 0, 1, 1);
        expect_ev(b + 26, 0, 0, 1, 0, 1);
        reset_req = 1'b1;
        step(5);
        reset_req = 1'b0;
        step(24);

        // Single-cycle pulse during HOLD at timer=10 restarts the full hold.
        b = cyc;
        expect_ev(b + 1, 1, 1, 0, 1, 2);
        reset_req = 1'b1;
        step(2);
        reset_req = 1'b0;
        step(11);
        expect_ev(b + 14, 1, 1, 0, 1, 3);
        expect_ev(b + 31, 0, 1, 0, 1, 3);
        expect_ev(b + 35, 0, 0, 1, 0, 3);
        reset_req = 1'b1;
        step(1);
        reset_req = 1'b0;
        step(24);

        // Terminal-count collisions: HOLD timer=15, then STAGE timer=3.
        b = cyc;
        expect_ev(b + 1, 1, 1, 0, 1, 4);
        reset_req = 1'b1;
        step(1);
        reset_req = 1'b0;
        step(16);
        expect_ev(b + 18, 1, 1, 0, 1, 5);
        expect_ev(b + 35, 0, 1, 0, 1, 5);
        reset_req = 1'b1;
        step(1);
        reset_req = 1'b0;
        step(20);
        expect_ev(b + 39, 1, 1, 0, 1, 6);
        expect_ev(b + 56, 0, 1, 0, 1, 6);
        expect_ev(b + 60, 0, 0, 1, 0, 6);
        reset_req = 1'b1;
        step(1);
        reset_req = 1'b0;
        step(24);

        // Async reset mid-STAGE, dropped between edges.
        b = cyc;
        expect_ev(b + 1,  1, 1, 0, 1, 7);
        expect_ev(b + 18, 0, 1, 0, 1, 7);
        reset_req = 1'b1;
        step(1);
        reset_req = 1'b0;
        step(19);
        expect_ev(b + 20, 1, 1, 0, 1, 0);
        #1;
        rst_n = 1'b0;
        step(3);
        b = cyc;
        expect_ev(b + 17, 0, 1, 0, 1, 0);
        expect_ev(b + 21, 0, 0, 1, 0, 0);
        rst_n = 1'b1;
        step(24);

        // Saturation on the 2-bit counter instance.
        for (int i = 0; i < 5; i++) begin
            exp2_q.push_back((i < 3) ? 2'(i + 1) : 2'd3);
            reset_req2 = 1'b1;
            step(1);
            reset_req2 = 1'b0;
            step(2);
        end
        step(5);

        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL missing_events got %0d pending, required 0", exp_q.size());
        end else begin
            n_pass++;
        end
        n_checks++;
        if (exp2_q.size() != 0) begin
            $display("FAIL missing_sat_reads got %0d pending, required 0", exp2_q.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
